// File: rtl/menu_nav_if.sv
// Button and display-side signals of the menu navigator.
// The bench or button logic is the master; menu_nav is the slave.
interface menu_nav_if #(
  parameter int NUM_BITS = 4
);
  logic                btn_up;
  logic                btn_down;
  logic                btn_sel;
  logic [NUM_BITS-1:0] top_choice;
  logic [NUM_BITS-1:0] choice;
  logic                sel_valid;
  logic [NUM_BITS-1:0] sel_choice;
  logic                at_top;
  logic                at_bottom;

  modport master (
    output btn_up,
    output btn_down,
    output btn_sel,
    output top_choice,
    input  choice,
    input  sel_valid,
    input  sel_choice,
    input  at_top,
    input  at_bottom
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  btn_sel,
    input  top_choice,
    output choice,
    output sel_valid,
    output sel_choice,
    output at_top,
    output at_bottom
  );
endinterface

// File: rtl/menu_nav.sv
// Menu choice navigator: up/down stepping with wrap or saturate,
// hold-to-auto-repeat, runtime top clamp and a select strobe.
module menu_nav #(
  parameter int NUM_BITS      = 4,
  parameter int BOTTOM_CHOICE = 0,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic      clk_in,
  input  logic      rst_in,
  menu_nav_if.slave bus
);

  localparam logic [NUM_BITS-1:0] BOT =
    NUM_BITS'(BOTTOM_CHOICE);
  localparam logic [NUM_BITS-1:0] ONE =
    NUM_BITS'(1);
  localparam int MAXC =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LD =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LD =
    CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  typedef enum logic [1:0] {
    D_NONE,
    D_UP,
    D_DOWN
  } dir_t;

  state_t              state;
  dir_t                held;
  logic [CW-1:0]       cnt;
  logic [NUM_BITS-1:0] choice_q;
  logic                sel_q;
  logic                sel_valid_q;
  logic [NUM_BITS-1:0] sel_choice_q;

  dir_t                dir;
  logic [NUM_BITS-1:0] eff_top;
  logic [NUM_BITS-1:0] up_val;
  logic [NUM_BITS-1:0] down_val;
  logic [NUM_BITS-1:0] step_val;
  logic                no_dir;
  logic                new_press;
  logic                tick;
  logic                clamp;
  logic                sel_rise;

  always_comb begin
    dir = D_NONE;
    if (bus.btn_up && !bus.btn_down)
      dir = D_UP;
    else if (bus.btn_down && !bus.btn_up)
      dir = D_DOWN;
  end

  always_comb begin
    eff_top = (bus.top_choice > BOT) ?
              bus.top_choice : BOT;
    up_val = BOT;
    if (choice_q > BOT)
      up_val = choice_q - ONE;
    else if (WRAP != 0)
      up_val = eff_top;
    down_val = eff_top;
    if (choice_q < eff_top)
      down_val = choice_q + ONE;
    else if (WRAP != 0)
      down_val = BOT;
    step_val = (dir == D_UP) ?
               up_val : down_val;
  end

  // A direction differing from the held one restarts the hold timer.
  always_comb begin
    no_dir    = (dir == D_NONE);
    new_press = !no_dir &&
                ((state == S_IDLE) ||
                 (dir != held));
    tick      = !no_dir && !new_press &&
                (cnt == '0);
    clamp     = (choice_q > eff_top);
    sel_rise  = bus.btn_sel && !sel_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= S_IDLE;
      held         <= D_NONE;
      cnt          <= '0;
      choice_q     <= BOT;
      sel_q        <= 1'b0;
      sel_valid_q  <= 1'b0;
      sel_choice_q <= BOT;
    end else begin
      sel_q       <= bus.btn_sel;
      sel_valid_q <= sel_rise;
      if (sel_rise)
        sel_choice_q <= choice_q;

      unique case (1'b1)
        no_dir: begin
          state <= S_IDLE;
          held  <= D_NONE;
          cnt   <= '0;
        end
        new_press: begin
          choice_q <= step_val;
          state    <= S_HOLD;
          held     <= dir;
          cnt      <= HOLD_LD;
        end
        tick: begin
          choice_q <= step_val;
          state    <= S_REPEAT;
          cnt      <= REP_LD;
        end
        default: begin
          cnt <= cnt - 1'b1;
        end
      endcase

      // Clamp wins over a same-cycle step.
      if (clamp)
        choice_q <= eff_top;
    end
  end

  assign bus.choice     = choice_q;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.sel_choice = sel_choice_q;
  assign bus.at_top     = (choice_q == eff_top);
  assign bus.at_bottom  = (choice_q == BOT);

endmodule

// File: tb/tb_menu_nav.sv
// Bench for menu_nav: wrap and saturate instances driven in lockstep,
// checked against a hold-age model plus literal expectations.
module tb_menu_nav;

  localparam int NB  = 4;
  localparam int BOT = 1;
  localparam int H   = 4;
  localparam int R   = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic up = 1'b0;
  logic down = 1'b0;
  logic sel = 1'b0;
  logic [NB-1:0] top = 4'd5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  menu_nav_if #(.NUM_BITS(NB)) if_w ();
  menu_nav_if #(.NUM_BITS(NB)) if_s ();

  assign if_w.btn_up     = up;
  assign if_w.btn_down   = down;
  assign if_w.btn_sel    = sel;
  assign if_w.top_choice = top;
  assign if_s.btn_up     = up;
  assign if_s.btn_down   = down;
  assign if_s.btn_sel    = sel;
  assign if_s.top_choice = top;

  menu_nav #(
    .NUM_BITS(NB), .BOTTOM_CHOICE(BOT), .WRAP(1),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) u_wrap (
    .clk_in(clk_in), .rst_in(rst_in), .bus(if_w)
  );

  menu_nav #(
    .NUM_BITS(NB), .BOTTOM_CHOICE(BOT), .WRAP(0),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) u_sat (
    .clk_in(clk_in), .rst_in(rst_in), .bus(if_s)
  );

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model: choice per instance, plus the age of the current press.
  int  m_choice[2];
  int  m_selc[2];
  bit  m_selv[2];
  int  age;
  int  hdir;
  bit  psel;
  bit  mvalid = 1'b0;

  function automatic int stepf(int c, int d, int et, bit w);
    if (d < 0)
      return (c > BOT) ? c - 1 : (w ? et : BOT);
    return (c < et) ? c + 1 : (w ? BOT : et);
  endfunction

  task automatic model_edge();
    int d;
    int et;
    bit stp;
    bit rise;
    mvalid = 1'b1;
    if (!rst_in) begin
      for (int m = 0; m < 2; m++) begin
        m_choice[m] = BOT;
        m_selc[m]   = BOT;
        m_selv[m]   = 1'b0;
      end
      age = -1; hdir = 0; psel = 1'b0;
      return;
    end
    d = (up && !down) ? -1 : ((down && !up) ? 1 : 0);
    stp = 1'b0;
    if (d == 0) begin
      age = -1; hdir = 0;
    end else if (d != hdir) begin
      age = 0; hdir = d; stp = 1'b1;
    end else begin
      age++;
      stp = (age >= H) && (((age - H) % R) == 0);
    end
    et = (int'(top) > BOT) ? int'(top) : BOT;
    rise = sel && !psel;
    for (int m = 0; m < 2; m++) begin
      m_selv[m] = rise;
      if (rise) m_selc[m] = m_choice[m];
      if (m_choice[m] > et)
        m_choice[m] = et;
      else if (stp)
        m_choice[m] = stepf(m_choice[m], d, et, m == 0);
    end
    psel = sel;
  endtask

  initial begin
    int et;
    forever begin
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      #1;
      if (mvalid) begin
        et = (int'(top) > BOT) ? int'(top) : BOT;
        chk("w.choice", int'(if_w.choice), m_choice[0]);
        chk("w.selv", int'(if_w.sel_valid), int'(m_selv[0]));
        chk("w.selc", int'(if_w.sel_choice), m_selc[0]);
        chk("w.top", int'(if_w.at_top), int'(m_choice[0] == et));
        chk("w.bot", int'(if_w.at_bottom), int'(m_choice[0] == BOT));
        chk("s.choice", int'(if_s.choice), m_choice[1]);
        chk("s.selv", int'(if_s.sel_valid), int'(m_selv[1]));
        chk("s.selc", int'(if_s.sel_choice), m_selc[1]);
        chk("s.top", int'(if_s.at_top), int'(m_choice[1] == et));
        chk("s.bot", int'(if_s.at_bottom), int'(m_choice[1] == BOT));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_down();
    down = 1'b1; cyc(1); down = 1'b0; cyc(1);
  endtask

  task automatic pulse_up();
    up = 1'b1; cyc(1); up = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0; cyc(2); rst_in = 1'b1;
  endtask

  initial begin
    int exp_w[12];
    exp_w = '{2, 2, 2, 2, 3, 3, 4, 4, 5, 5, 1, 1};

    cyc(2);
    rst_in = 1'b1;
    chk("t1.reset_choice", int'(if_w.choice), 1);
    chk("t1.reset_bot", int'(if_w.at_bottom), 1);
    chk("t1.reset_selv", int'(if_w.sel_valid), 0);

    for (int i = 1; i <= 3; i++) begin
      pulse_down();
      chk("t1.step", int'(if_w.choice), 1 + i);
      chk("t1.notbot", int'(if_w.at_bottom), 0);
    end

    pulse_down();
    chk("t2.w5", int'(if_w.choice), 5);
    chk("t2.w_top", int'(if_w.at_top), 1);
    pulse_down();
    chk("t2.w_wrap_dn", int'(if_w.choice), 1);
    chk("t2.s_sat_dn", int'(if_s.choice), 5);
    pulse_up();
    chk("t2.w_wrap_up", int'(if_w.choice), 5);
    chk("t2.s_up", int'(if_s.choice), 4);
    do_reset();
    cyc(1);
    pulse_up();
    chk("t2.w_up_at_bot", int'(if_w.choice), 5);
    chk("t2.s_sat_up", int'(if_s.choice), 1);

    do_reset();
    cyc(1);
    down = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk("t3.hold", int'(if_w.choice), exp_w[k]);
    end
    chk("t3.s_hold", int'(if_s.choice), 5);
    down = 1'b0;
    cyc(6);
    chk("t3.released", int'(if_w.choice), 1);

    up = 1'b1; down = 1'b1;
    cyc(10);
    chk("t4.both_w", int'(if_w.choice), 1);
    chk("t4.both_s", int'(if_s.choice), 5);
    up = 1'b0;
    cyc(1);
    chk("t4.drop_up", int'(if_w.choice), 2);
    down = 1'b0;
    cyc(1);

    for (int i = 0; i < 3; i++) pulse_down();
    chk("t5.w5", int'(if_w.choice), 5);
    top = 4'd3;
    cyc(1);
    chk("t5.clamp3_w", int'(if_w.choice), 3);
    chk("t5.clamp3_s", int'(if_s.choice), 3);
    top = 4'd0;
    cyc(1);
    chk("t5.clamp0", int'(if_w.choice), 1);
    chk("t5.top0", int'(if_w.at_top), 1);
    top = 4'd5;
    cyc(1);

    for (int i = 0; i < 3; i++) pulse_down();
    chk("t6.pre", int'(if_w.choice), 4);
    sel = 1'b1; down = 1'b1;
    cyc(1);
    down = 1'b0;
    chk("t6.selv", int'(if_w.sel_valid), 1);
    chk("t6.selc", int'(if_w.sel_choice), 4);
    chk("t6.choice", int'(if_w.choice), 5);
    cyc(1);
    chk("t6.one_strobe", int'(if_w.sel_valid), 0);
    cyc(2);
    down = 1'b1;
    cyc(2);
    rst_in = 1'b0;
    cyc(1);
    chk("t6.rst_choice", int'(if_w.choice), 1);
    chk("t6.rst_selv", int'(if_w.sel_valid), 0);
    chk("t6.rst_selc", int'(if_w.sel_choice), 1);
    rst_in = 1'b1;
    cyc(1);
    chk("t6.repress", int'(if_w.choice), 2);
    chk("t6.resel", int'(if_w.sel_valid), 1);
    sel = 1'b0; down = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
